// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions: the 4-bit ALU op codes, the 2-bit ALUOp encodings
// produced by the main decoder, the R-type funct codes, and default widths.
// Used by alu_ctrl and id_ex_stage, and reusable by the single-cycle datapath.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_AW_DEFAULT = 5;

    // ALU op codes as seen on the ALU's op input.
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;

    // ALUOp field from the main decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    // R-type funct field values understood by the ALU.
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
// Combinational ALU control: translates the decoder's ALUOp and the R-type
// funct field into the 4-bit ALU op code. Unsupported combinations (reserved
// ALUOp or an unknown funct) yield op=OP_AND (0000) with illegal raised.
//
// Ports:
//   aluop    in   2  ALUOp from the main decoder
//   funct    in   6  R-type funct field
//   op       out  4  ALU op code
//   illegal  out  1  combination not supported by the ALU
// -----------------------------------------------------------------------------
module alu_ctrl
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        op      = OP_AND;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: op = OP_ADD;
                    FUNCT_SUB: op = OP_SUB;
                    FUNCT_AND: op = OP_AND;
                    FUNCT_OR:  op = OP_OR;
                    FUNCT_NOR: op = OP_NOR;
                    FUNCT_XOR: op = OP_XOR;
                    FUNCT_SLT: op = OP_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// One-entry ID/EX pipeline register feeding the ALU. Captures decoded
// operands and control, translates ALUOp/funct into the ALU op code, and
// (optionally) resolves EX/MEM and MEM/WB forwarding at capture time.
// Valid/ready handshake on both sides; flush drops held and incoming entries.
//
// Build option: define ID_EX_FORWARD_EN to enable operand forwarding. When
// undefined, operands come straight from the register file / immediate and
// the exm_*/mwb_* inputs are ignored.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i / ready_o            upstream handshake (decode side)
//   rs_data_i, rt_data_i, imm_i  register-file data and immediate
//   rs_i, rt_i, rd_i             source and destination indices
//   aluop_i, funct_i, alusrc_i   ALU control from decode
//   regwrite_i                   instruction writes the register file
//   exm_*, mwb_*                 forwarding producers (EX/MEM, MEM/WB)
//   flush_i                      discard held and incoming entry
//   valid_o / ready_i            downstream handshake (ALU side)
//   a_o, b_o, op_o               ALU operands and op code
//   rd_o, regwrite_o             carried-forward write-back control
//   illegal_o                    held entry had unsupported aluop/funct
// -----------------------------------------------------------------------------
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [1:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic              alusrc_i,
    input  logic              regwrite_i,
    input  logic              exm_regwrite_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [DATA_W-1:0] exm_data_i,
    input  logic              mwb_regwrite_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic [DATA_W-1:0] mwb_data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [3:0]        op_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              regwrite_o,
    output logic              illegal_o
);

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [3:0]        dec_op;
    logic              dec_illegal;
    logic              capture;

    alu_ctrl u_alu_ctrl (
        .aluop   (aluop_i),
        .funct   (funct_i),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer, so it is checked first. Index 0 is the
    // hard-wired zero register and never forwarded.
    always_comb begin
        rs_fwd = rs_data_i;
        if (exm_regwrite_i && exm_rd_i == rs_i && rs_i != '0)
            rs_fwd = exm_data_i;
        else if (mwb_regwrite_i && mwb_rd_i == rs_i && rs_i != '0)
            rs_fwd = mwb_data_i;
    end

    always_comb begin
        rt_fwd = rt_data_i;
        if (exm_regwrite_i && exm_rd_i == rt_i && rt_i != '0)
            rt_fwd = exm_data_i;
        else if (mwb_regwrite_i && mwb_rd_i == rt_i && rt_i != '0)
            rt_fwd = mwb_data_i;
    end
`else
    // Without forwarding the hazard unit guarantees no RAW dependence.
    assign rs_fwd = rs_data_i;
    assign rt_fwd = rt_data_i;

    logic unused_fwd;
    assign unused_fwd = ^{rs_i, rt_i, exm_regwrite_i, exm_rd_i, exm_data_i,
                          mwb_regwrite_i, mwb_rd_i, mwb_data_i};
`endif

    // Empty or draining this cycle; held low during reset so decode never
    // believes an instruction was taken while the stage is being cleared.
    assign ready_o = !rst_i && (!valid_o || ready_i);
    assign capture = valid_i && ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst_i) begin
            valid_o    <= 1'b0;
            a_o        <= '0;
            b_o        <= '0;
            op_o       <= OP_AND;
            rd_o       <= '0;
            regwrite_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            regwrite_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (capture) begin
            valid_o    <= 1'b1;
            a_o        <= rs_fwd;
            b_o        <= alusrc_i ? imm_i : rt_fwd;
            op_o       <= dec_op;
            rd_o       <= rd_i;
            // An illegal instruction must never write back.
            regwrite_o <= regwrite_i && !dec_illegal;
            illegal_o  <= dec_illegal;
        end else if (ready_i) begin
            // Drain: the ALU took the entry and nothing new arrived.
            valid_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: table-driven decode vectors, directed
// multi-cycle sequences (reset, capture, forwarding, stall, flush, drain) and
// randomized traffic, all compared against a behavioural stage model.
// Honors ID_EX_FORWARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] rs_data_i = '0, rt_data_i = '0, imm_i = '0;
    logic [AW-1:0] rs_i = '0, rt_i = '0, rd_i = '0;
    logic [1:0]    aluop_i = '0;
    logic [5:0]    funct_i = '0;
    logic          alusrc_i = 1'b0, regwrite_i = 1'b0;
    logic          exm_regwrite_i = 1'b0, mwb_regwrite_i = 1'b0;
    logic [AW-1:0] exm_rd_i = '0, mwb_rd_i = '0;
    logic [DW-1:0] exm_data_i = '0, mwb_data_i = '0;
    logic          flush_i = 1'b0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [DW-1:0] a_o, b_o;
    logic [3:0]    op_o;
    logic [AW-1:0] rd_o;
    logic          regwrite_o, illegal_o;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .aluop_i(aluop_i), .funct_i(funct_i), .alusrc_i(alusrc_i),
        .regwrite_i(regwrite_i),
        .exm_regwrite_i(exm_regwrite_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
        .mwb_regwrite_i(mwb_regwrite_i), .mwb_rd_i(mwb_rd_i), .mwb_data_i(mwb_data_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .a_o(a_o), .b_o(b_o), .op_o(op_o), .rd_o(rd_o),
        .regwrite_o(regwrite_o), .illegal_o(illegal_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic          regwrite;
        logic          illegal;
        logic          kd;   // data fields defined
        logic          kc;   // regwrite/illegal defined
    } model_t;

    model_t m;
    int     op_table[int];   // R-type funct -> ALU op

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] s, input logic [DW-1:0] rf);
`ifdef ID_EX_FORWARD_EN
        if (s != 0 && exm_regwrite_i && exm_rd_i == s) return exm_data_i;
        if (s != 0 && mwb_regwrite_i && mwb_rd_i == s) return mwb_data_i;
`endif
        return rf;
    endfunction

    function automatic model_t capture_model();
        model_t e;
        e          = '0;
        e.valid    = 1'b1;
        e.kd       = 1'b1;
        e.kc       = 1'b1;
        e.a        = fwd(rs_i, rs_data_i);
        e.b        = alusrc_i ? imm_i : fwd(rt_i, rt_data_i);
        e.rd       = rd_i;
        if (aluop_i == 2'd0)      e.op = 4'd2;
        else if (aluop_i == 2'd1) e.op = 4'd6;
        else if (aluop_i == 2'd2 && op_table.exists(int'(funct_i))) e.op = 4'(op_table[int'(funct_i)]);
        else begin e.op = 4'd0; e.illegal = 1'b1; end
        e.regwrite = regwrite_i && !e.illegal;
        return e;
    endfunction

    // Advance one clock: predict, clock, then compare everything defined.
    task automatic tick();
        model_t nx;
        logic   m_ready;
        m_ready = !rst_i && (!m.valid || ready_i);
        nx = m;
        if (rst_i) begin
            nx = '0; nx.kd = 1'b1; nx.kc = 1'b1;
        end else if (flush_i) begin
            nx.valid = 0; nx.regwrite = 0; nx.illegal = 0; nx.kc = 1; nx.kd = 0;
        end else if (valid_i && m_ready) begin
            nx = capture_model();
        end else if (!(m.valid && !ready_i)) begin
            nx.valid = 0; nx.kc = 0; nx.kd = 0;
        end
        @(posedge clk);
        #1;
        m = nx;
        check("valid_o", valid_o, m.valid);
        check("ready_o", ready_o, !rst_i && (!m.valid || ready_i));
        if (m.kc) begin
            check("regwrite_o", regwrite_o, m.regwrite);
            check("illegal_o", illegal_o, m.illegal);
        end
        if (m.kd) begin
            check("a_o", a_o, m.a);
            check("b_o", b_o, m.b);
            check("op_o", op_o, m.op);
            check("rd_o", rd_o, m.rd);
        end
    endtask

    task automatic set_instr(input logic [AW-1:0] rs, input logic [DW-1:0] rsd,
                             input logic [AW-1:0] rt, input logic [DW-1:0] rtd,
                             input logic [1:0] aluop, input logic [5:0] funct,
                             input logic alusrc, input logic [DW-1:0] imm);
        rs_i = rs; rs_data_i = rsd; rt_i = rt; rt_data_i = rtd;
        aluop_i = aluop; funct_i = funct; alusrc_i = alusrc; imm_i = imm;
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [1:0]    aluop;
        logic [5:0]    funct;
        logic          alusrc;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp_b;
        logic [3:0]    exp_op;
        logic          exp_ill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [DW-1:0] exp_a;
        logic [5:0]    funct_list [7];

        op_table[6'b100000] = 4'b0010; op_table[6'b100010] = 4'b0110;
        op_table[6'b100100] = 4'b0000; op_table[6'b100101] = 4'b0001;
        op_table[6'b100111] = 4'b1100; op_table[6'b100110] = 4'b1101;
        op_table[6'b101010] = 4'b0111;
        funct_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2a};

        // rt data is 0x1234 for every row; imm used only when alusrc=1.
        vecs.push_back('{2'b10, 6'b100000, 1'b0, 32'h0,        32'h1234,     4'b0010, 1'b0});
        vecs.push_back('{2'b10, 6'b100010, 1'b0, 32'h0,        32'h1234,     4'b0110, 1'b0});
        vecs.push_back('{2'b10, 6'b100100, 1'b0, 32'h0,        32'h1234,     4'b0000, 1'b0});
        vecs.push_back('{2'b10, 6'b100101, 1'b0, 32'h0,        32'h1234,     4'b0001, 1'b0});
        vecs.push_back('{2'b10, 6'b100111, 1'b0, 32'h0,        32'h1234,     4'b1100, 1'b0});
        vecs.push_back('{2'b10, 6'b100110, 1'b0, 32'h0,        32'h1234,     4'b1101, 1'b0});
        vecs.push_back('{2'b10, 6'b101010, 1'b0, 32'h0,        32'h1234,     4'b0111, 1'b0});
        vecs.push_back('{2'b00, 6'b000000, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 4'b0010, 1'b0});
        vecs.push_back('{2'b01, 6'b111111, 1'b0, 32'h0,        32'h1234,     4'b0110, 1'b0});
        vecs.push_back('{2'b10, 6'b000001, 1'b0, 32'h0,        32'h1234,     4'b0000, 1'b1});
        vecs.push_back('{2'b11, 6'b100000, 1'b0, 32'h0,        32'h1234,     4'b0000, 1'b1});

        m = '0;

        // ---- reset then idle ----
        rst_i = 1'b1;
        tick(); tick();
        check("rst a_o", a_o, 0);
        check("rst op_o", op_o, 0);
        check("rst ready_o", ready_o, 0);
        rst_i = 1'b0;
        #1;
        check("post-rst ready_o", ready_o, 1);
        tick();
        check("idle valid_o", valid_o, 0);

        // ---- basic capture ----
        set_instr(5'd3, 32'd5, 5'd4, 32'd7, 2'b10, 6'b100000, 1'b0, 32'h0);
        rd_i = 5'd9; regwrite_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        check("basic a_o", a_o, 5);
        check("basic b_o", b_o, 7);
        check("basic op_o", op_o, 4'b0010);
        check("basic rd_o", rd_o, 9);
        check("basic regwrite_o", regwrite_o, 1);

        // ---- decode table ----
        rd_i = 5'd1; rs_i = 5'd1; rs_data_i = 32'h11; rt_i = 5'd2; rt_data_i = 32'h1234;
        foreach (vecs[i]) begin
            aluop_i = vecs[i].aluop; funct_i = vecs[i].funct;
            alusrc_i = vecs[i].alusrc; imm_i = vecs[i].imm;
            tick();
            check($sformatf("vec%0d op_o", i), op_o, vecs[i].exp_op);
            check($sformatf("vec%0d illegal_o", i), illegal_o, vecs[i].exp_ill);
            check($sformatf("vec%0d b_o", i), b_o, vecs[i].exp_b);
            check($sformatf("vec%0d regwrite_o", i), regwrite_o, !vecs[i].exp_ill);
        end

        // ---- forward priority ----
        set_instr(5'd8, 32'h11, 5'd8, 32'h22, 2'b00, 6'h0, 1'b0, 32'h0);
        exm_regwrite_i = 1; exm_rd_i = 5'd8; exm_data_i = 32'hAA;
        mwb_regwrite_i = 1; mwb_rd_i = 5'd8; mwb_data_i = 32'hBB;
        tick();
`ifdef ID_EX_FORWARD_EN
        exp_a = 32'hAA;
`else
        exp_a = 32'h11;
`endif
        check("fwd exm-wins a_o", a_o, exp_a);
        exm_regwrite_i = 0;
        tick();
`ifdef ID_EX_FORWARD_EN
        exp_a = 32'hBB;
`else
        exp_a = 32'h11;
`endif
        check("fwd mwb a_o", a_o, exp_a);
        exm_regwrite_i = 1; exm_rd_i = 0; mwb_rd_i = 0; rs_i = 0; rt_i = 0;
        tick();
        check("fwd r0 a_o", a_o, 32'h11);
        check("fwd r0 b_o", b_o, 32'h22);
        exm_regwrite_i = 0; mwb_regwrite_i = 0;

        // ---- stall ----
        set_instr(5'd6, 32'h66, 5'd7, 32'h77, 2'b01, 6'h0, 1'b0, 32'h0);
        tick();
        ready_i = 1'b0;
        set_instr(5'd5, 32'h55, 5'd2, 32'h99, 2'b00, 6'h0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            exm_regwrite_i = 1; exm_rd_i = 5'd6; exm_data_i = $urandom;
            mwb_regwrite_i = 1; mwb_rd_i = 5'd7; mwb_data_i = $urandom;
            tick();
            check("stall a_o", a_o, 32'h66);
            check("stall b_o", b_o, 32'h77);
            check("stall op_o", op_o, 4'b0110);
            check("stall ready_o", ready_o, 0);
        end
        exm_regwrite_i = 0; mwb_regwrite_i = 0;
        ready_i = 1'b1;
        tick();
        check("stall release a_o", a_o, 32'h55);
        check("stall release b_o", b_o, 32'h99);

        // ---- drain ----
        valid_i = 1'b0;
        tick();
        check("drain valid_o", valid_o, 0);

        // ---- flush vs capture, and flush of a held entry ----
        valid_i = 1'b1; flush_i = 1'b1;
        tick();
        check("flush-capture valid_o", valid_o, 0);
        flush_i = 1'b0; aluop_i = 2'b10; funct_i = 6'b000001; regwrite_i = 1;
        tick();
        check("illegal op_o", op_o, 0);
        check("illegal illegal_o", illegal_o, 1);
        check("illegal regwrite_o", regwrite_o, 0);
        ready_i = 1'b0; flush_i = 1'b1;
        tick();
        check("flush-held illegal_o", illegal_o, 0);
        flush_i = 1'b0;

        // ---- reset mid-stall ----
        aluop_i = 2'b00; ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        check("rst-stall valid_o", valid_o, 0);
        rst_i = 1'b0; ready_i = 1'b1;
        tick();

        // ---- randomized traffic ----
        for (int c = 0; c < 400; c++) begin
            rst_i          = ($urandom_range(0, 49) == 0);
            flush_i        = ($urandom_range(0, 9) == 0);
            valid_i        = ($urandom_range(0, 3) != 0);
            ready_i        = ($urandom_range(0, 3) != 0);
            rs_i           = AW'($urandom_range(0, 3));
            rt_i           = AW'($urandom_range(0, 3));
            rd_i           = AW'($urandom_range(0, 31));
            rs_data_i      = $urandom; rt_data_i = $urandom; imm_i = $urandom;
            aluop_i        = 2'($urandom_range(0, 3));
            funct_i        = ($urandom_range(0, 4) != 0) ? funct_list[$urandom_range(0, 6)]
                                                         : 6'($urandom);
            alusrc_i       = 1'($urandom);
            regwrite_i     = 1'($urandom);
            exm_regwrite_i = 1'($urandom);
            exm_rd_i       = AW'($urandom_range(0, 3));
            exm_data_i     = $urandom;
            mwb_regwrite_i = 1'($urandom);
            mwb_rd_i       = AW'($urandom_range(0, 3));
            mwb_data_i     = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
